reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- In-order retirement buffer between decoder/issue and the architectural register file.
- Allocates a rename tag per decoded instruction and collects results from the ALU and load/store CDB ports.
- Retires the head entry in program order, driving the register-file commit port (enable, reg index, rename tag, value).
- Flushes the whole speculative window when a mispredicted branch retires.

Parameters:
- ROB_DEPTH, 16, number of entries; power of two.
- TAG_W, 4, rename tag width, log2(ROB_DEPTH).
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; when low, no state change
- alloc_valid  in  1  decoder requests an entry
- alloc_has_rd  in  1  instruction writes rd
- alloc_rd  in  5  destination register index
- alloc_is_store  in  1  instruction is a store
- alloc_tag  out  TAG_W  tag granted; equals tail, combinational
- rob_full  out  1  count==ROB_DEPTH, from registered count
- alu_wb_valid  in  1  ALU CDB write
- alu_wb_tag  in  TAG_W  ALU CDB tag
- alu_wb_value  in  XLEN  ALU CDB result
- alu_wb_mispredict  in  1  branch resolved mispredicted
- alu_wb_target  in  XLEN  correct PC for mispredict
- lsb_wb_valid  in  1  LSB CDB write
- lsb_wb_tag  in  TAG_W  LSB CDB tag
- lsb_wb_value  in  XLEN  LSB CDB result
- q1_tag, q2_tag  in  TAG_W each  operand-forward queries
- q1_ready, q2_ready  out  1 each  queried entry has a result
- q1_value, q2_value  out  XLEN each  queried entry's result
- commit_en  out  1  register-file write pulse
- commit_reg  out  5  destination index
- commit_rename  out  TAG_W  tag being retired
- commit_value  out  XLEN  retired value
- commit_store  out  1  pulse: LSB may perform the head store
- flush  out  1  pulse: squash all speculative state
- flush_pc  out  XLEN  redirect PC

Behaviour:
- Reset (async, rst=1):
  - head, tail and count are 0; all busy/ready bits are 0.
  - commit_en, commit_store and flush are 0.
  - commit_reg, commit_rename, commit_value and flush_pc are 0.
- rdy=0: entry state is held; pulse outputs are 0 at the next edge.
- Allocation:
  - Accepted at an edge when alloc_valid & !rob_full & !flush_cond.
  - The entry at tail gets busy=1, ready=0, has_rd, rd, is_store and mispredict=0; tail and count are incremented.
  - tail wraps from ROB_DEPTH-1 to 0.
- Full:
  - rob_full uses the registered count.
  - An allocation in the same cycle as a commit from a full buffer is refused.
- Writeback:
  - On each valid CDB port whose tag entry is busy, the edge sets ready=1 and stores the value.
  - The ALU port also latches mispredict and target.
  - A writeback to a non-busy entry is ignored.
  - Both ports may write different tags in one cycle; same-tag collision is illegal and must be flagged by an assertion.
- Query:
  - q*_ready is high when the entry is busy & ready, or when a valid CDB port carries that tag this cycle.
  - On a CDB match, the CDB value is forwarded; ALU has priority over LSB.
- Commit condition: count!=0 and head entry ready. Stores additionally need their writeback (address/data resolved) before ready is set.
- On a commit edge:
  - head is freed and incremented with wrap; count is decremented.
  - commit_en = has_rd & (rd!=0); commit_reg = rd; commit_rename = head; commit_value = value.
  - commit_store = is_store.
  - All pulse outputs are registered and high for exactly one cycle per retirement; at most one retirement per cycle.
- Simultaneous allocation and commit: count is unchanged; head and tail both advance.
- Flush (flush_cond = commit of an entry with mispredict=1):
  - That entry's register write still commits.
  - flush=1 and flush_pc=target for one cycle.
  - At the same edge, head, tail, count and all busy bits are cleared; allocation and writebacks that cycle are discarded.
- Commit latency: a result written at edge N can commit at edge N+1 at the earliest.

Decomposition:
- Shared package (define include):
  - ROB_DEPTH, TAG_W, XLEN and the "not renamed" tag constant.
  - The ROB entry struct fields: busy, ready, has_rd, rd, is_store, mispredict, value, target.
- Single module; the entry array plus head/tail/count logic is too small to justify a sub-module.

Test Plan:
- Allocate / writeback / commit: reset, allocate three entries (rd=1,2,3); write tags 2,1,0 with values 0x30,0x20,0x10 -> commits in order: tag0/rd1/0x10, then tag1/rd2/0x20, then tag2/rd3/0x30, one per cycle.
- Full: allocate 16 entries -> rob_full=1 and the 17th request is not granted. Ready+commit the head while requesting a new entry -> the request is refused that cycle and granted the next with tag 0 (wrap).
- Query forwarding: q1_tag=5 pending while alu_wb writes tag 5 value 0xDEAD -> q1_ready=1, q1_value=0xDEAD in the same cycle.
- Mispredict: entries 0..3, tag1 ALU writeback with mispredict=1 and target 0x100 -> tag0 then tag1 commit; flush=1 with flush_pc=0x100 in tag1's commit cycle; count=0 next cycle; tags 2 and 3 never commit.
- Special commits: store entry readied -> commit_store=1 with commit_en=0. Entry with rd=0 -> commit_en=0.
- Stall and reset: hold rdy=0 with a ready head -> no commit until rdy=1. Assert rst asynchronously mid-stream -> all outputs 0 immediately and the buffer is empty.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Shared sizing constants and the ROB entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int TAG_W     = 4;
    localparam int XLEN      = 32;

    // Value the commit rename port rests at when nothing has retired
    localparam logic [TAG_W-1:0] NOT_RENAMED = '0;

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic            has_rd;
        logic [4:0]      rd;
        logic            is_store;
        logic            mispredict;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] target;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement buffer with CDB capture, operand query
//               forwarding and whole-window flush on mispredicted branches.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic             alloc_has_rd,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_store,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             rob_full,
    input  logic             alu_wb_valid,
    input  logic [TAG_W-1:0] alu_wb_tag,
    input  logic [XLEN-1:0]  alu_wb_value,
    input  logic             alu_wb_mispredict,
    input  logic [XLEN-1:0]  alu_wb_target,
    input  logic             lsb_wb_valid,
    input  logic [TAG_W-1:0] lsb_wb_tag,
    input  logic [XLEN-1:0]  lsb_wb_value,
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q1_value,
    output logic [XLEN-1:0]  q2_value,
    output logic             commit_en,
    output logic [4:0]       commit_reg,
    output logic [TAG_W-1:0] commit_rename,
    output logic [XLEN-1:0]  commit_value,
    output logic             commit_store,
    output logic             flush,
    output logic [XLEN-1:0]  flush_pc
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

    rob_entry_t       rob_q [ROB_DEPTH];
    rob_entry_t       rob_d [ROB_DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             commit_en_q, commit_en_d;
    logic [4:0]       commit_reg_q, commit_reg_d;
    logic [TAG_W-1:0] commit_rename_q, commit_rename_d;
    logic [XLEN-1:0]  commit_value_q, commit_value_d;
    logic             commit_store_q, commit_store_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

    rob_entry_t head_e;
    logic       commit_fire;
    logic       flush_cond;
    logic       alloc_fire;

    assign head_e      = rob_q[head_q];
    assign rob_full    = (count_q == FULL_COUNT);
    assign alloc_tag   = tail_q;
    assign commit_fire = rdy && (count_q != '0) && head_e.busy && head_e.ready;
    assign flush_cond  = commit_fire && head_e.mispredict;
    assign alloc_fire  = rdy && alloc_valid && !rob_full && !flush_cond;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_d[i] = rob_q[i];
        end
        if (rdy) begin
            if (alu_wb_valid && rob_q[alu_wb_tag].busy) begin
                rob_d[alu_wb_tag].ready      = 1'b1;
                rob_d[alu_wb_tag].value      = alu_wb_value;
                rob_d[alu_wb_tag].mispredict = alu_wb_mispredict;
                rob_d[alu_wb_tag].target     = alu_wb_target;
            end
            if (lsb_wb_valid && rob_q[lsb_wb_tag].busy) begin
                rob_d[lsb_wb_tag].ready = 1'b1;
                rob_d[lsb_wb_tag].value = lsb_wb_value;
            end
            if (alloc_fire) begin
                rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, has_rd: alloc_has_rd,
                                  rd: alloc_rd, is_store: alloc_is_store,
                                  mispredict: 1'b0, value: '0, target: '0};
            end
            if (commit_fire) begin
                rob_d[head_q].busy  = 1'b0;
                rob_d[head_q].ready = 1'b0;
            end
            // A retiring mispredict squashes everything, including this cycle's writebacks
            if (flush_cond) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    rob_d[i].busy  = 1'b0;
                    rob_d[i].ready = 1'b0;
                end
            end
        end
    end

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_en_d     = 1'b0;
        commit_store_d  = 1'b0;
        flush_d         = 1'b0;
        commit_reg_d    = commit_reg_q;
        commit_rename_d = commit_rename_q;
        commit_value_d  = commit_value_q;
        flush_pc_d      = flush_pc_q;
        if (commit_fire) begin
            head_d          = head_q + 1'b1;
            commit_en_d     = head_e.has_rd && (head_e.rd != 5'd0);
            commit_reg_d    = head_e.rd;
            commit_rename_d = head_q;
            commit_value_d  = head_e.value;
            commit_store_d  = head_e.is_store;
        end
        if (alloc_fire) begin
            tail_d = tail_q + 1'b1;
        end
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_cond) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            flush_d    = 1'b1;
            flush_pc_d = head_e.target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_en_q     <= 1'b0;
            commit_reg_q    <= '0;
            commit_rename_q <= NOT_RENAMED;
            commit_value_q  <= '0;
            commit_store_q  <= 1'b0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= rob_d[i];
            end
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_en_q     <= commit_en_d;
            commit_reg_q    <= commit_reg_d;
            commit_rename_q <= commit_rename_d;
            commit_value_q  <= commit_value_d;
            commit_store_q  <= commit_store_d;
            flush_q         <= flush_d;
            flush_pc_q      <= flush_pc_d;
        end
    end

    assign commit_en     = commit_en_q;
    assign commit_reg    = commit_reg_q;
    assign commit_rename = commit_rename_q;
    assign commit_value  = commit_value_q;
    assign commit_store  = commit_store_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;

    logic [TAG_W-1:0] q_tag   [2];
    logic             q_ready [2];
    logic [XLEN-1:0]  q_value [2];

    assign q_tag[0] = q1_tag;
    assign q_tag[1] = q2_tag;

    // Same-cycle CDB results bypass the array; ALU wins over LSB
    for (genvar p = 0; p < 2; p++) begin : g_query
        always_comb begin
            q_ready[p] = rob_q[q_tag[p]].busy && rob_q[q_tag[p]].ready;
            q_value[p] = rob_q[q_tag[p]].value;
            if (alu_wb_valid && (alu_wb_tag == q_tag[p])) begin
                q_ready[p] = 1'b1;
                q_value[p] = alu_wb_value;
            end else if (lsb_wb_valid && (lsb_wb_tag == q_tag[p])) begin
                q_ready[p] = 1'b1;
                q_value[p] = lsb_wb_value;
            end
        end
    end

    assign q1_ready = q_ready[0];
    assign q2_ready = q_ready[1];
    assign q1_value = q_value[0];
    assign q2_value = q_value[1];

`ifndef SYNTHESIS
    // Both CDB ports targeting one tag in the same cycle is an upstream bug
    a_no_cdb_collision : assert property (@(posedge clk) disable iff (rst)
        !(alu_wb_valid && lsb_wb_valid && (alu_wb_tag == lsb_wb_tag)));
`endif

endmodule
`default_nettype wire
